// File: rtl/trilat_grid_search.sv
// Exhaustive 2-D grid search for the point whose squared distances to three fixed
// anchors best match the squared input distances; one grid point per clock.
module trilat_grid_search #(
  parameter int GRID_W = 64,
  parameter int GRID_H = 64,
  parameter int AX     = 2,
  parameter int AY     = 2,
  parameter int BX     = 62,
  parameter int BY     = 2,
  parameter int CX     = 62,
  parameter int CY     = 62,
  parameter int TOL    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  dist_a,
  input  logic [7:0]  dist_b,
  input  logic [7:0]  dist_c,
  output logic        busy,
  output logic        done,
  output logic [7:0]  pos_x,
  output logic [7:0]  pos_y,
  output logic [17:0] min_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_FIN} state_t;

  localparam logic [7:0]  XMAX  = 8'(GRID_W - 1);
  localparam logic [7:0]  YMAX  = 8'(GRID_H - 1);
  localparam logic [7:0]  AX_V  = 8'(AX);
  localparam logic [7:0]  AY_V  = 8'(AY);
  localparam logic [7:0]  BX_V  = 8'(BX);
  localparam logic [7:0]  BY_V  = 8'(BY);
  localparam logic [7:0]  CX_V  = 8'(CX);
  localparam logic [7:0]  CY_V  = 8'(CY);
  localparam logic [17:0] TOL_V = 18'(TOL);

  function automatic logic [7:0] absdiff8(input logic [7:0] a, input logic [7:0] p);
    return (a > p) ? a - p : p - a;
  endfunction

  function automatic logic [16:0] sqdist(input logic [7:0] ax, input logic [7:0] ay,
                                         input logic [7:0] px, input logic [7:0] py);
    logic [16:0] dx, dy;
    dx = 17'(absdiff8(ax, px));
    dy = 17'(absdiff8(ay, py));
    return dx * dx + dy * dy;
  endfunction

  function automatic logic [16:0] absdiff17(input logic [16:0] dd, input logic [15:0] sq);
    return (dd > 17'(sq)) ? dd - 17'(sq) : 17'(sq) - dd;
  endfunction

  // Clamp rather than wrap if an out-of-range parameterisation ever overflows 18 bits.
  function automatic logic [17:0] sat18(input logic [18:0] s);
    return s[18] ? 18'h3FFFF : s[17:0];
  endfunction

  state_t      r_state;
  logic [7:0]  r_da, r_db, r_dc;
  logic [15:0] r_sqa, r_sqb, r_sqc;
  logic [7:0]  r_x, r_y, r_bx, r_by;
  logic [17:0] r_best;

  logic [16:0] w_ea, w_eb, w_ec;
  logic [17:0] w_err, w_nbest;
  logic [7:0]  w_nbx, w_nby;
  logic        w_better, w_hit, w_last;

  always_comb begin
    w_ea     = absdiff17(sqdist(AX_V, AY_V, r_x, r_y), r_sqa);
    w_eb     = absdiff17(sqdist(BX_V, BY_V, r_x, r_y), r_sqb);
    w_ec     = absdiff17(sqdist(CX_V, CY_V, r_x, r_y), r_sqc);
    w_err    = sat18(19'(w_ea) + 19'(w_eb) + 19'(w_ec));
    w_better = (w_err < r_best);
    w_nbest  = w_better ? w_err : r_best;
    w_nbx    = w_better ? r_x : r_bx;
    w_nby    = w_better ? r_y : r_by;
    w_hit    = (w_err <= TOL_V);
    w_last   = (r_x == XMAX) && (r_y == YMAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      pos_x   <= '0;
      pos_y   <= '0;
      min_err <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_best  <= 18'h3FFFF;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_da    <= dist_a;
            r_db    <= dist_b;
            r_dc    <= dist_c;
            busy    <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_sqa   <= 16'(r_da) * 16'(r_da);
          r_sqb   <= 16'(r_db) * 16'(r_db);
          r_sqc   <= 16'(r_dc) * 16'(r_dc);
          r_x     <= '0;
          r_y     <= '0;
          r_best  <= 18'h3FFFF;
          r_state <= S_SCAN;
        end
        S_SCAN: begin
          r_best <= w_nbest;
          r_bx   <= w_nbx;
          r_by   <= w_nby;
          // An early hit is always strictly better than any earlier point, so the
          // updated best registers already hold the hit point.
          if (w_hit || w_last) begin
            pos_x   <= w_nbx;
            pos_y   <= w_nby;
            min_err <= w_nbest;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_FIN;
          end else if (r_x == XMAX) begin
            r_x <= '0;
            r_y <= r_y + 8'd1;
          end else begin
            r_x <= r_x + 8'd1;
          end
        end
        S_FIN: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trilat_grid_search.sv
// Scoreboard bench for trilat_grid_search: expected results come from an exhaustive
// search model and are compared whenever done pulses.
module tb_trilat_grid_search;

  localparam int GRID_W = 64, GRID_H = 64;
  localparam int AX = 2, AY = 2, BX = 62, BY = 2, CX = 62, CY = 62;
  localparam int TOL = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  dist_a = '0, dist_b = '0, dist_c = '0;
  logic        busy, done;
  logic [7:0]  pos_x, pos_y;
  logic [17:0] min_err;

  always #5 clk = ~clk;

  trilat_grid_search #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .AX(AX), .AY(AY), .BX(BX), .BY(BY),
    .CX(CX), .CY(CY), .TOL(TOL)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .dist_a(dist_a), .dist_b(dist_b), .dist_c(dist_c),
    .busy(busy), .done(done), .pos_x(pos_x), .pos_y(pos_y), .min_err(min_err)
  );

  typedef struct {int x; int y; int err; int k;} exp_t;
  exp_t sbq[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, busy_cnt = 0, n_done = 0;
  bit searching = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic exp_t model(input int a, input int b, input int c);
    exp_t e;
    int best, err;
    best = 'h3FFFF;
    e = '{0, 0, 0, GRID_W * GRID_H - 1};
    for (int y = 0; y < GRID_H; y++) begin
      for (int x = 0; x < GRID_W; x++) begin
        err = iabs((AX-x)*(AX-x) + (AY-y)*(AY-y) - a*a)
            + iabs((BX-x)*(BX-x) + (BY-y)*(BY-y) - b*b)
            + iabs((CX-x)*(CX-x) + (CY-y)*(CY-y) - c*c);
        if (err < best) begin
          best = err;
          e.x = x;
          e.y = y;
        end
        if (err <= TOL) begin
          e.k = y * GRID_W + x;
          e.err = best;
          return e;
        end
      end
    end
    e.err = best;
    return e;
  endfunction

  always @(negedge clk) begin
    if (searching && busy) busy_cnt++;
    if (done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("pos_x", 32'(pos_x), 32'(e.x));
        chk("pos_y", 32'(pos_y), 32'(e.y));
        chk("min_err", 32'(min_err), 32'(e.err));
        chk("latency", 32'(cyc - start_cyc), 32'(2 + e.k));
        chk("busy_cycles", 32'(busy_cnt), 32'(2 + e.k));
      end
      searching = 1'b0;
      n_done++;
    end
  end

  // Drive start from just after a negedge and hold it until busy shows acceptance.
  task automatic launch(input int a, input int b, input int c);
    bit ok;
    ok = 1'b0;
    dist_a = 8'(a);
    dist_b = 8'(b);
    dist_c = 8'(c);
    sbq.push_back(model(a, b, c));
    start = 1'b1;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (busy) begin
        ok = 1'b1;
        start_cyc = cyc;
        busy_cnt = 0;
        searching = 1'b1;
      end
    end
    start = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n0;
    bit seen;
    n0 = n_done;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (n_done > n0) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_at(input int rel);
    while (cyc - start_cyc < rel) @(negedge clk);
    dist_a = 8'd60;
    dist_b = 8'd0;
    dist_c = 8'd60;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Triples with an exact integer solution on the grid, so TOL=0 exits early.
  int exact_a[9] = '{60, 49, 35, 28, 15, 61, 65, 68, 75};
  int exact_b[9] = '{ 0, 11, 25, 32, 45, 11, 25, 32, 45};
  int exact_c[9] = '{60, 61, 65, 68, 75, 49, 35, 28, 15};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pos_x", 32'(pos_x), 32'd0);
    chk("rst_pos_y", 32'(pos_y), 32'd0);
    chk("rst_min_err", 32'(min_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_busy", 32'(busy), 32'd0);

    launch(60, 0, 60);
    wait_done(300);
    chk("c1_x", 32'(pos_x), 32'd62);
    chk("c1_y", 32'(pos_y), 32'd2);
    chk("c1_err", 32'(min_err), 32'd0);
    @(negedge clk);
    chk("c1_done_one_cycle", 32'(done), 32'd0);

    launch(0, 0, 0);
    wait_done(5000);
    chk("c2_x", 32'(pos_x), 32'd42);
    chk("c2_y", 32'(pos_y), 32'd22);
    chk("c2_err", 32'(min_err), 32'd4800);

    launch(0, 0, 0);
    pulse_at(10);
    pulse_at(3000);
    wait_done(5000);
    chk("c3_x", 32'(pos_x), 32'd42);
    chk("c3_err", 32'(min_err), 32'd4800);
    launch(60, 0, 60);
    wait_done(300);
    chk("c3b_x", 32'(pos_x), 32'd62);
    chk("c3b_err", 32'(min_err), 32'd0);

    launch(0, 0, 0);
    while (cyc - start_cyc < 2000) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_pos_x", 32'(pos_x), 32'd0);
    chk("mid_rst_pos_y", 32'(pos_y), 32'd0);
    chk("mid_rst_err", 32'(min_err), 32'd0);
    sbq.delete();
    searching = 1'b0;
    repeat (2200) @(negedge clk);
    #1;
    launch(60, 0, 60);
    wait_done(300);
    chk("c4_x", 32'(pos_x), 32'd62);

    launch(255, 255, 255);
    wait_done(5000);

    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        int j;
        j = int'($urandom_range(0, 8));
        launch(exact_a[j], exact_b[j], exact_c[j]);
      end else begin
        launch(int'($urandom_range(0, 100)), int'($urandom_range(0, 100)),
               int'($urandom_range(0, 100)));
      end
      wait_done(5000);
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
